// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
//
// Parametrised Johnson (twisted-ring) counter. Used as a low-glitch sequencer
// or phase generator wherever a 2*WIDTH-state ring is needed. It steps up or
// down, supports a parallel load, and decodes the current code to a state
// index and a one-hot vector. It also flags codes that are not legal Johnson
// codes and gives a registered pulse when the sequence wraps.
//
// Optional build macro:
//   JOHNSON_SELF_CORRECT_EN - an enabled step taken from an illegal code
//                             forces q to 0, so the ring recovers in one
//                             cycle. Without it, illegal codes keep shifting
//                             with the normal equations.
//
// Parameters:
//   WIDTH  number of flip-flops (2..16); the sequence length is 2*WIDTH
//   IDXW   width of idx; derived from WIDTH, do not override
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   en        in   count enable, one step per edge
//   dir       in   1 = up (forward), 0 = down (reverse)
//   load      in   synchronous parallel load; takes priority over en
//   load_val  in   value written to q on load
//   q         out  counter register
//   idx       out  state index 0..2*WIDTH-1 (0 when the code is illegal)
//   dec       out  one-hot decode of idx (all zeros when the code is illegal)
//   wrap      out  registered one-cycle pulse after a wrapping step
//   illegal   out  q is not a legal Johnson code
// -----------------------------------------------------------------------------
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2*WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     q,
    output logic [IDXW-1:0]      idx,
    output logic [2*WIDTH-1:0]   dec,
    output logic                 wrap,
    output logic                 illegal
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("johnson_counter_param: WIDTH must be in 2..16");
    end
    if (IDXW != $clog2(2*WIDTH)) begin : g_bad_idxw
        $error("johnson_counter_param: IDXW must not be overridden");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2*WIDTH - 1);

    logic [IDXW-1:0]  pc;
    logic [WIDTH-1:0] q_rev;
    logic [WIDTH-1:0] ones_lo;
    logic             form_a;
    logic             form_b;
    logic [IDXW-1:0]  idx_c;
    logic             illegal_c;
    logic [WIDTH-1:0] q_step;
    logic             wrap_step;

    // A legal code has all its ones in one contiguous run. The run either
    // touches the LSB (form A, first half of the ring) or touches the MSB
    // (form B, second half). Form B is form A bit-reversed, so a single
    // "popcount ones at the bottom" mask tests both forms.
    always_comb begin
        pc    = '0;
        q_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc          = pc + IDXW'(q[i]);
            q_rev[i]    = q[WIDTH-1-i];
        end
        ones_lo = WIDTH'((32'd1 << pc) - 32'd1);
        form_a  = (q == ones_lo);
        // The all-zero and all-one codes belong to form A only.
        form_b  = (q_rev == ones_lo) && (pc != '0) && (int'(pc) != WIDTH);

        if (form_a) begin
            idx_c = pc;
        end else if (form_b) begin
            idx_c = IDXW'(2*WIDTH - int'(pc));
        end else begin
            idx_c = '0;
        end
        illegal_c = !(form_a || form_b);
    end

    always_comb begin
        if (dir) begin
            q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
        end else begin
            q_step = {~q[0], q[WIDTH-1:1]};
        end
`ifdef JOHNSON_SELF_CORRECT_EN
        if (illegal_c) begin
            q_step = '0;
        end
`endif
        // Illegal codes also decode to idx 0, so legality gates the wrap.
        // This keeps wrap low both in an illegal orbit and on a correction step.
        wrap_step = !illegal_c && (dir ? (idx_c == LAST_IDX) : (idx_c == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q_step;
            wrap <= wrap_step;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign idx     = idx_c;
    assign illegal = illegal_c;
    assign dec     = illegal_c ? '0 : ({{(2*WIDTH-1){1'b0}}, 1'b1} << idx_c);

endmodule
